// File: rtl/nvm_pkg.sv
// Shared NVM controller types: block-pool FSM states, block addressing and GC thresholds.
package nvm_pkg;

  localparam int unsigned NUM_BLK_DEF  = 64;
  localparam int unsigned GC_THRESHOLD = 8;

  typedef logic [$clog2(NUM_BLK_DEF)-1:0] blk_addr_t;

  typedef enum logic {
    IDLE,
    RECOVER
  } fifo_state_t;

  typedef enum logic [1:0] {
    GC_IDLE,
    GC_REQ,
    GC_BUSY
  } gc_state_t;

endpackage

// File: rtl/clean_blk_ram.sv
// Single-write, single-read block-address array; write is synchronous, read is asynchronous.
module clean_blk_ram #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 6
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/clean_blk_fifo.sv
// Circular pool of clean NVM block addresses with init fill, allocation pops and
// power-up recovery by walking an external block-status table.
module clean_blk_fifo
  import nvm_pkg::*;
#(
  parameter int unsigned NUM_BLK = NUM_BLK_DEF,
  parameter int unsigned BLK_W   = $clog2(NUM_BLK),
  parameter int unsigned CNT_W   = $clog2(NUM_BLK + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             initial_fifo,
  input  logic             fifo_write_en,
  input  logic [BLK_W-1:0] push_blk,
  input  logic             pop_req,
  output logic [BLK_W-1:0] pop_blk,
  output logic             pop_valid,
  output logic [CNT_W-1:0] clean_num,
  output logic             ini_full,
  input  logic             recover_start,
  output logic             fifo_recover_en,
  output logic [BLK_W-1:0] status_idx,
  input  logic             blk_clean_in,
  output logic             overflow,
  output logic             underflow
);

  fifo_state_t      state;
  logic [BLK_W-1:0] rd, wr, rec_idx;
  logic [CNT_W-1:0] ini_idx;

  logic             full, empty;
  logic             idle_go, pop_ok, push_ok, rec_push, we;
  logic [BLK_W-1:0] wdata, rd_data;

  function automatic logic [BLK_W-1:0] ptr_next(input logic [BLK_W-1:0] ptr);
    return (ptr == BLK_W'(NUM_BLK - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full  = (clean_num == CNT_W'(NUM_BLK));
  assign empty = (clean_num == '0);

  always_comb begin
    idle_go  = (state == IDLE) && !recover_start;
    pop_ok   = idle_go && pop_req && !empty;
    // A same-cycle pop frees the slot, so a push into a full pool still lands.
    push_ok  = idle_go && fifo_write_en && (!full || pop_ok);
    rec_push = (state == RECOVER) && blk_clean_in;
    we       = push_ok || rec_push;
    if (rec_push) begin
      wdata = rec_idx;
    end else if (initial_fifo) begin
      wdata = ini_idx[BLK_W-1:0];
    end else begin
      wdata = push_blk;
    end
  end

  clean_blk_ram #(
    .DEPTH  (NUM_BLK),
    .ADDR_W (BLK_W),
    .DATA_W (BLK_W)
  ) u_ram (
    .CLK   (CLK),
    .we    (we),
    .waddr (wr),
    .wdata (wdata),
    .raddr (rd),
    .rdata (rd_data)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      rd        <= '0;
      wr        <= '0;
      rec_idx   <= '0;
      ini_idx   <= '0;
      clean_num <= '0;
      pop_blk   <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          pop_valid <= pop_ok;
          if (recover_start) begin
            state     <= RECOVER;
            rd        <= '0;
            wr        <= '0;
            clean_num <= '0;
            ini_idx   <= '0;
            rec_idx   <= '0;
          end else begin
            if (pop_ok) begin
              pop_blk <= rd_data;
              rd      <= ptr_next(rd);
            end
            if (push_ok) begin
              wr <= ptr_next(wr);
              if (initial_fifo) begin
                ini_idx <= ini_idx + 1'b1;
              end
            end
            if (push_ok && !pop_ok) begin
              clean_num <= clean_num + 1'b1;
            end else if (pop_ok && !push_ok) begin
              clean_num <= clean_num - 1'b1;
            end
            if (fifo_write_en && !push_ok) begin
              overflow <= 1'b1;
            end
            if (pop_req && empty) begin
              underflow <= 1'b1;
            end
          end
        end
        RECOVER: begin
          pop_valid <= 1'b0;
          if (rec_push) begin
            wr        <= ptr_next(wr);
            clean_num <= clean_num + 1'b1;
          end
          rec_idx <= ptr_next(rec_idx);
          if (rec_idx == BLK_W'(NUM_BLK - 1)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ini_full        = full;
  assign fifo_recover_en = (state == RECOVER);
  assign status_idx      = rec_idx;

endmodule

// File: tb/tb_clean_blk_fifo.sv
// Directed bench for clean_blk_fifo; expected pops go into a queue checked by a monitor.
module tb_clean_blk_fifo;

  localparam int unsigned NUM_BLK = 64;
  localparam int unsigned BLK_W   = 6;
  localparam int unsigned CNT_W   = 7;

  logic             CLK = 1'b0;
  logic             RST;
  logic             initial_fifo, fifo_write_en, pop_req, recover_start;
  logic [BLK_W-1:0] push_blk;
  logic [BLK_W-1:0] pop_blk;
  logic             pop_valid, ini_full, fifo_recover_en, overflow, underflow;
  logic [CNT_W-1:0] clean_num;
  logic [BLK_W-1:0] status_idx;
  logic             blk_clean_in;
  int               clean_mode;

  int               n_checks = 0;
  int               n_fail   = 0;
  int               exp_q[$];

  always #5 CLK = ~CLK;

  // 0: nothing clean, 1: even indices clean, 2: every index clean
  assign blk_clean_in = (clean_mode == 1) ? ~status_idx[0] : (clean_mode == 2);

  clean_blk_fifo #(
    .NUM_BLK (NUM_BLK),
    .BLK_W   (BLK_W),
    .CNT_W   (CNT_W)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .initial_fifo    (initial_fifo),
    .fifo_write_en   (fifo_write_en),
    .push_blk        (push_blk),
    .pop_req         (pop_req),
    .pop_blk         (pop_blk),
    .pop_valid       (pop_valid),
    .clean_num       (clean_num),
    .ini_full        (ini_full),
    .recover_start   (recover_start),
    .fifo_recover_en (fifo_recover_en),
    .status_idx      (status_idx),
    .blk_clean_in    (blk_clean_in),
    .overflow        (overflow),
    .underflow       (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic push_one(input int v);
    fifo_write_en = 1'b1;
    push_blk      = BLK_W'(v);
    tick();
    fifo_write_en = 1'b0;
  endtask

  task automatic pop_one(input int exp);
    pop_req = 1'b1;
    exp_q.push_back(exp);
    tick();
    pop_req = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pop_blk"}, 32'(pop_blk), 0);
    chk({tag, "_pop_valid"}, 32'(pop_valid), 0);
    chk({tag, "_clean_num"}, 32'(clean_num), 0);
    chk({tag, "_ini_full"}, 32'(ini_full), 0);
    chk({tag, "_recover_en"}, 32'(fifo_recover_en), 0);
    chk({tag, "_status_idx"}, 32'(status_idx), 0);
    chk({tag, "_overflow"}, 32'(overflow), 0);
    chk({tag, "_underflow"}, 32'(underflow), 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Monitor: every pop_valid must match the oldest expected pop.
  initial begin
    forever begin
      @(negedge CLK);
      if (pop_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop_valid", 32'(pop_blk), 32'hFFFF_FFFF);
        end else begin
          chk("pop_blk", 32'(pop_blk), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    RST           = 1'b1;
    initial_fifo  = 1'b0;
    fifo_write_en = 1'b0;
    pop_req       = 1'b0;
    recover_start = 1'b0;
    push_blk      = '0;
    clean_mode    = 0;
    tick();
    tick();
    sample();
    chk_reset("rst");
    RST = 1'b0;
    tick();

    // Init fill then drain in order
    initial_fifo  = 1'b1;
    fifo_write_en = 1'b1;
    repeat (NUM_BLK) tick();
    fifo_write_en = 1'b0;
    initial_fifo  = 1'b0;
    sample();
    chk("init_clean_num", 32'(clean_num), 64);
    chk("init_ini_full", 32'(ini_full), 1);
    for (int i = 0; i < 64; i++) pop_one(i);
    sample();
    chk("init_drain_clean_num", 32'(clean_num), 0);
    chk("init_drain_ini_full", 32'(ini_full), 0);

    // Pointer wrap: rd/wr sit at 0 again, 60 then 10 crosses the wrap
    for (int i = 0; i < 60; i++) push_one((i * 7 + 3) % 64);
    for (int i = 0; i < 60; i++) pop_one((i * 7 + 3) % 64);
    for (int i = 0; i < 10; i++) push_one((i * 11 + 1) % 64);
    for (int i = 0; i < 10; i++) pop_one((i * 11 + 1) % 64);
    sample();
    chk("wrap_clean_num", 32'(clean_num), 0);
    chk("wrap_overflow", 32'(overflow), 0);
    chk("wrap_underflow", 32'(underflow), 0);

    // Full boundaries
    for (int i = 0; i < 64; i++) push_one(i ^ 5);
    sample();
    chk("full_clean_num", 32'(clean_num), 64);
    chk("full_overflow_pre", 32'(overflow), 0);
    fifo_write_en = 1'b1;
    pop_req       = 1'b1;
    push_blk      = 6'd42;
    exp_q.push_back(5);
    tick();
    fifo_write_en = 1'b0;
    pop_req       = 1'b0;
    sample();
    chk("full_pushpop_clean_num", 32'(clean_num), 64);
    chk("full_pushpop_overflow", 32'(overflow), 0);
    push_one(17);
    sample();
    chk("overflow_set", 32'(overflow), 1);
    chk("overflow_clean_num", 32'(clean_num), 64);
    for (int i = 1; i < 64; i++) pop_one(i ^ 5);
    pop_one(42);
    sample();
    chk("drain_clean_num", 32'(clean_num), 0);

    // Empty boundaries
    pop_req = 1'b1;
    tick();
    pop_req = 1'b0;
    sample();
    chk("underflow_set", 32'(underflow), 1);
    chk("underflow_pop_valid", 32'(pop_valid), 0);
    fifo_write_en = 1'b1;
    pop_req       = 1'b1;
    push_blk      = 6'd9;
    tick();
    fifo_write_en = 1'b0;
    pop_req       = 1'b0;
    sample();
    chk("empty_pushpop_clean_num", 32'(clean_num), 1);
    chk("empty_pushpop_pop_valid", 32'(pop_valid), 0);
    pop_one(9);
    sample();
    chk("empty_pushpop_drain", 32'(clean_num), 0);

    // Recovery with even blocks clean, external traffic held high throughout
    do_reset();
    clean_mode    = 1;
    recover_start = 1'b1;
    tick();
    recover_start = 1'b0;
    pop_req       = 1'b1;
    fifo_write_en = 1'b1;
    push_blk      = 6'd5;
    cnt           = 0;
    while (fifo_recover_en === 1'b1 && cnt < 200) begin
      cnt++;
      tick();
    end
    pop_req       = 1'b0;
    fifo_write_en = 1'b0;
    clean_mode    = 0;
    chk("recover_cycles", 32'(cnt), 64);
    sample();
    chk("recover_clean_num", 32'(clean_num), 32);
    chk("recover_overflow", 32'(overflow), 0);
    chk("recover_underflow", 32'(underflow), 0);
    chk("recover_en_done", 32'(fifo_recover_en), 0);
    for (int i = 0; i < 32; i++) pop_one(2 * i);
    sample();
    chk("recover_drain", 32'(clean_num), 0);

    // Reset in the middle of a recovery walk
    clean_mode    = 2;
    recover_start = 1'b1;
    tick();
    recover_start = 1'b0;
    repeat (20) tick();
    sample();
    chk("midrec_status_idx", 32'(status_idx), 20);
    chk("midrec_clean_num", 32'(clean_num), 20);
    chk("midrec_recover_en", 32'(fifo_recover_en), 1);
    RST = 1'b1;
    tick();
    sample();
    chk_reset("midrec_rst");
    RST        = 1'b0;
    clean_mode = 0;
    tick();
    push_one(33);
    pop_one(33);
    sample();
    chk("post_rst_clean_num", 32'(clean_num), 0);
    chk("post_rst_recover_en", 32'(fifo_recover_en), 0);

    repeat (3) tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clean_blk_fifo.md
# clean_blk_fifo

Circular free-block pool that tracks every erased (clean) NVM block address. It sits directly downstream of the garbage-collection controller: it takes the controller's init-fill and block-cleaned push strobes, and it returns the clean-block count, full and recovery status the controller uses to decide GC requests and interrupts. The write path pops clean blocks from it for allocation. On request it also rebuilds its contents after power-up by walking an external block-status table.

## Interface
Parameters:
- NUM_BLK, 64, number of physical blocks; also the FIFO depth
- BLK_W, $clog2(NUM_BLK), block address width
- CNT_W, $clog2(NUM_BLK+1), clean-count width

Ports:
- CLK  in  1  clock; all logic on the rising edge
- RST  in  1  reset, synchronous, active-high
- initial_fifo  in  1  init mode; a push writes the internal init index instead of push_blk
- fifo_write_en  in  1  push strobe
- push_blk  in  BLK_W  block address to push in normal mode
- pop_req  in  1  allocation request from the write path
- pop_blk  out  BLK_W  allocated block address
- pop_valid  out  1  pop_blk valid; one-cycle pulse
- clean_num  out  CNT_W  current occupancy
- ini_full  out  1  occupancy == NUM_BLK
- recover_start  in  1  begin a recovery walk; pulse
- fifo_recover_en  out  1  recovery walk in progress
- status_idx  out  BLK_W  block index being queried during recovery
- blk_clean_in  in  1  combinational status reply for status_idx (1 = clean)
- overflow  out  1  sticky: push attempted while full
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage is an NUM_BLK x BLK_W array with head (rd) and tail (wr) pointers. Pointers wrap from NUM_BLK-1 to 0. clean_num is the explicit occupancy counter; full and empty are derived from clean_num, not from pointer comparison.
- Push (fifo_write_en=1, state IDLE):
  - With initial_fifo=1, the block writes ini_idx and then increments ini_idx. ini_idx resets to 0 and is not wrapped.
  - With initial_fifo=0, the block writes push_blk.
  - If the FIFO is full, the push is dropped and overflow is set.
- Pop (pop_req=1, state IDLE):
  - If not empty, mem[rd] is registered into pop_blk, pop_valid is set for one cycle, and rd advances.
  - If empty, the pop is dropped, pop_valid stays 0 and underflow is set.
- Simultaneous push and pop:
  - Not empty: both proceed and clean_num is unchanged.
  - Full: both proceed; the push does not overflow because the pop frees a slot in the same cycle.
  - Empty: the pop fails (underflow) and the push succeeds.
- FSM (fifo_state_t):
  - IDLE: on recover_start, go to RECOVER; rd, wr, clean_num and ini_idx are cleared in the same cycle.
  - RECOVER: fifo_recover_en=1 and status_idx=rec_idx. If blk_clean_in=1, rec_idx is pushed. rec_idx increments every cycle. After the rec_idx==NUM_BLK-1 cycle, go to IDLE. External pushes and pops are ignored in this state (no flags set, pop_valid=0).
  - recover_start while in RECOVER is ignored.
- overflow and underflow clear only on RST.

## Timing
- Reset values: pop_blk=0, pop_valid=0, clean_num=0, ini_full=0, fifo_recover_en=0, status_idx=0, overflow=0, underflow=0, state=IDLE, rd=wr=ini_idx=rec_idx=0.
- RST asserted mid-recovery or mid-init aborts the operation and returns to the reset values on the next edge. Array contents are don't-care.
- Pop latency: pop_blk and pop_valid are valid the cycle after pop_req.
- clean_num, ini_full and the sticky flags update on the edge that commits the push or pop.
- Recovery takes exactly NUM_BLK cycles in RECOVER. fifo_recover_en drops on the edge after the last index is sampled.
- An init fill of NUM_BLK consecutive pushes raises ini_full on the edge after the final push.

## Structure
- Shared package nvm_pkg holds:
  - fifo_state_t {IDLE, RECOVER}
  - NUM_BLK default and block-address typedef blk_addr_t
  - GC_THRESHOLD, alongside the existing gc_state_t
- One sub-module: clean_blk_ram, a single-write, single-read synchronous array with asynchronous read. The read is registered in the parent.
- Counters, pointers and the FSM stay in clean_blk_fifo.

## Test plan
- Init fill: NUM_BLK cycles of initial_fifo=1 with fifo_write_en=1 -> clean_num=64 and ini_full=1. The next 64 pops return 0..63 in order; then clean_num=0.
- Wrap: push 60 and pop 60, then push 10 and pop 10 -> the pops return the pushed values in order across the pointer wrap; clean_num=0 and no flags set.
- Boundaries:
  - Full plus a lone push -> overflow=1 and clean_num stays 64.
  - Full with push and pop in the same cycle -> clean_num stays 64 and no overflow.
  - Pop while empty -> underflow=1 and pop_valid=0.
- Recovery: blk_clean_in=1 only for even status_idx -> fifo_recover_en high for 64 cycles, clean_num=32, and the pops return 0, 2, 4, …, 62.
- Recovery isolation: pop_req and fifo_write_en held high during RECOVER -> no pop_valid, flags unchanged, and clean_num equals the recovered count only.
- Reset mid-recovery: RST at rec_idx=20 -> the next cycle shows all reset values and state IDLE.
